// File: rtl/pc_gen_pkg.sv
// Shared widths, the fetch-address bundle and reset-PC helper
// for the multithreaded PC generator.
package pc_gen_pkg;

    localparam int XLEN         = 32;
    localparam int THREAD_WIDTH = 2;
    localparam int INSTR_WIDTH  = 32;
    localparam int NUM_THREADS  = 1 << THREAD_WIDTH;

    typedef struct packed {
        logic                    valid;
        logic [THREAD_WIDTH-1:0] thread_id;
        logic [XLEN-1:0]         pc;
    } pc_gen_out_t;

    function automatic logic [XLEN-1:0] word_align(
        input logic [XLEN-1:0] a
    );
        return a & ~XLEN'(3);
    endfunction

    function automatic logic [XLEN-1:0] thread_reset_pc(
        input logic [XLEN-1:0] base,
        input logic [XLEN-1:0] stride,
        input int              t
    );
        return base + XLEN'(t) * stride;
    endfunction

endpackage

// File: rtl/pc_gen_rr_arbiter.sv
// Round-robin arbiter: scans upward from the slot after the last
// grant and returns a one-hot grant plus its index.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         valid
);

    always_comb begin
        int         ci;
        logic [W-1:0] c;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        ci    = 0;
        c     = '0;
        for (int k = 1; k <= N; k++) begin
            ci = (int'(last) + k) % N;
            c  = W'(ci);
            if (!valid && req[c]) begin
                valid  = 1'b1;
                gnt[c] = 1'b1;
                idx    = c;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Per-thread program counters with round-robin issue of one
// registered {thread, pc} fetch address per unstalled cycle.
import pc_gen_pkg::*;

module pc_gen #(
    parameter logic [XLEN-1:0] RESET_PC      = 32'h0000_0000,
    parameter logic [XLEN-1:0] THREAD_STRIDE = 32'h0000_1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_i,
    input  logic [NUM_THREADS-1:0]  thread_en_i,
    input  logic                    redirect_valid_i,
    input  logic [THREAD_WIDTH-1:0] redirect_thread_i,
    input  logic [XLEN-1:0]         redirect_pc_i,
    output logic                    pc_valid_o,
    output logic [THREAD_WIDTH-1:0] pc_thread_id_o,
    output logic [XLEN-1:0]         pc_pc_o
);

    logic [XLEN-1:0]         pc_q [NUM_THREADS];
    logic [XLEN-1:0]         pc_d [NUM_THREADS];
    logic [THREAD_WIDTH-1:0] last_q, last_d;
    pc_gen_out_t             out_q, out_d;

    logic [NUM_THREADS-1:0]  redir_mask;
    logic [NUM_THREADS-1:0]  eligible;
    logic [NUM_THREADS-1:0]  gnt;
    logic [THREAD_WIDTH-1:0] sel;
    logic                    any;
    logic                    issue;
    logic                    squash;
    logic [XLEN-1:0]         redir_pc;

    always_comb begin
        redir_mask = '0;
        if (redirect_valid_i)
            redir_mask[redirect_thread_i] = 1'b1;
    end

    assign eligible = thread_en_i & ~redir_mask;
    assign redir_pc = word_align(redirect_pc_i);

    rr_arbiter #(
        .N (NUM_THREADS),
        .W (THREAD_WIDTH)
    ) u_arb (
        .req   (eligible),
        .last  (last_q),
        .gnt   (gnt),
        .idx   (sel),
        .valid (any)
    );

    assign issue  = !stall_i && any;
    // A held address for the redirected thread must never reach fetch.
    assign squash = stall_i && redirect_valid_i && out_q.valid
                    && (out_q.thread_id == redirect_thread_i);

    always_comb begin
        pc_d   = pc_q;
        last_d = last_q;
        out_d  = out_q;
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (redir_mask[t])
                pc_d[t] = redir_pc;
            else if (issue && gnt[t])
                pc_d[t] = pc_q[t] + XLEN'(4);
        end
        if (!stall_i) begin
            if (any) begin
                out_d.valid     = 1'b1;
                out_d.thread_id = sel;
                out_d.pc        = pc_q[sel];
                last_d          = sel;
            end else begin
                out_d.valid = 1'b0;
            end
        end else if (squash) begin
            out_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int t = 0; t < NUM_THREADS; t++)
                pc_q[t] <= thread_reset_pc(RESET_PC, THREAD_STRIDE, t);
            last_q <= THREAD_WIDTH'(NUM_THREADS - 1);
            out_q  <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++)
                pc_q[t] <= pc_d[t];
            last_q <= last_d;
            out_q  <= out_d;
        end
    end

    assign pc_valid_o     = out_q.valid;
    assign pc_thread_id_o = out_q.thread_id;
    assign pc_pc_o        = out_q.pc;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a reference model queues the expected
// output per cycle; directed scenarios also check literal addresses.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic [3:0]  thread_en_i;
    logic        redirect_valid_i;
    logic [1:0]  redirect_thread_i;
    logic [31:0] redirect_pc_i;
    logic        pc_valid_o;
    logic [1:0]  pc_thread_id_o;
    logic [31:0] pc_pc_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          v;
        int          tid;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] m_pc [4];
    int          m_last;
    bit          m_v;
    int          m_tid;
    logic [31:0] m_opc;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .thread_en_i       (thread_en_i),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_thread_i (redirect_thread_i),
        .redirect_pc_i     (redirect_pc_i),
        .pc_valid_o        (pc_valid_o),
        .pc_thread_id_o    (pc_thread_id_o),
        .pc_pc_o           (pc_pc_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < 4; t++)
            m_pc[t] = 32'h1000 * t;
        m_last = 3;
        m_v    = 0;
        m_tid  = 0;
        m_opc  = 0;
    endtask

    task automatic model_edge();
        int s;
        int c;
        s = -1;
        for (int k = 1; k <= 4; k++) begin
            c = (m_last + k) % 4;
            if (s < 0 && thread_en_i[c]
                && !(redirect_valid_i && redirect_thread_i == c))
                s = c;
        end
        if (!stall_i) begin
            if (s >= 0) begin
                m_v     = 1;
                m_tid   = s;
                m_opc   = m_pc[s];
                m_pc[s] = m_pc[s] + 4;
                m_last  = s;
            end else begin
                m_v = 0;
            end
        end else if (redirect_valid_i && m_v && m_tid == redirect_thread_i) begin
            m_v = 0;
        end
        if (redirect_valid_i)
            m_pc[redirect_thread_i] = {redirect_pc_i[31:2], 2'b00};
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        e.v   = m_v;
        e.tid = m_tid;
        e.pc  = m_opc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb_valid", {31'b0, pc_valid_o}, {31'b0, e.v});
        if (e.v) begin
            check("sb_tid", {30'b0, pc_thread_id_o}, e.tid);
            check("sb_pc", pc_pc_o, e.pc);
        end
    endtask

    task automatic go(input string tag, input bit v, input int t,
                      input logic [31:0] pc);
        step();
        check({tag, "_v"}, {31'b0, pc_valid_o}, {31'b0, v});
        if (v) begin
            check({tag, "_t"}, {30'b0, pc_thread_id_o}, t);
            check({tag, "_pc"}, pc_pc_o, pc);
        end
    endtask

    task automatic idle_inputs();
        stall_i           = 0;
        thread_en_i       = 4'hF;
        redirect_valid_i  = 0;
        redirect_thread_i = 0;
        redirect_pc_i     = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        #1;
        check("rst_v", {31'b0, pc_valid_o}, 0);
        check("rst_t", {30'b0, pc_thread_id_o}, 0);
        check("rst_pc", pc_pc_o, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic redirect(input int t, input logic [31:0] pc);
        redirect_valid_i  = 1;
        redirect_thread_i = 2'(t);
        redirect_pc_i     = pc;
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        #1;
        do_reset();

        // Round-robin from reset
        go("a0", 1, 0, 32'h0000);
        go("a1", 1, 1, 32'h1000);
        go("a2", 1, 2, 32'h2000);
        go("a3", 1, 3, 32'h3000);
        go("a4", 1, 0, 32'h0004);

        // Partial enable, then all halted
        do_reset();
        thread_en_i = 4'b0101;
        go("b0", 1, 0, 32'h0000);
        go("b1", 1, 2, 32'h2000);
        go("b2", 1, 0, 32'h0004);
        go("b3", 1, 2, 32'h2004);
        thread_en_i = 4'b0000;
        go("b4", 0, 0, 0);
        go("b5", 0, 0, 0);
        thread_en_i = 4'hF;
        go("b6", 1, 3, 32'h3000);
        go("b7", 1, 0, 32'h0008);
        go("b8", 1, 1, 32'h1000);
        go("b9", 1, 2, 32'h2008);

        // Stall holds output
        do_reset();
        go("c0", 1, 0, 32'h0000);
        go("c1", 1, 1, 32'h1000);
        stall_i = 1;
        for (int i = 0; i < 3; i++)
            go("c_hold", 1, 1, 32'h1000);
        stall_i = 0;
        go("c2", 1, 2, 32'h2000);
        go("c3", 1, 3, 32'h3000);
        go("c4", 1, 0, 32'h0004);
        go("c5", 1, 1, 32'h1004);

        // Unstalled redirect skips the thread that cycle
        do_reset();
        go("d0", 1, 0, 32'h0000);
        redirect(1, 32'h0000_8003);
        go("d1", 1, 2, 32'h2000);
        idle_inputs();
        go("d2", 1, 3, 32'h3000);
        go("d3", 1, 0, 32'h0004);
        go("d4", 1, 1, 32'h8000);
        go("d5", 1, 2, 32'h2004);
        go("d6", 1, 3, 32'h3004);
        go("d7", 1, 0, 32'h0008);
        go("d8", 1, 1, 32'h8004);

        // Stalled redirect squashes the held address
        do_reset();
        go("e0", 1, 0, 32'h0000);
        go("e1", 1, 1, 32'h1000);
        go("e2", 1, 2, 32'h2000);
        stall_i = 1;
        redirect(2, 32'h0000_4000);
        go("e3", 0, 0, 0);
        redirect_valid_i = 0;
        go("e4", 0, 0, 0);
        stall_i = 0;
        go("e5", 1, 3, 32'h3000);
        go("e6", 1, 0, 32'h0004);
        go("e7", 1, 1, 32'h1004);
        go("e8", 1, 2, 32'h4000);

        // PC wrap, then reset in the middle of a stall
        do_reset();
        redirect(0, 32'hFFFF_FFFC);
        go("f0", 1, 1, 32'h1000);
        idle_inputs();
        thread_en_i = 4'b0001;
        go("f1", 1, 0, 32'hFFFF_FFFC);
        go("f2", 1, 0, 32'h0000_0000);
        stall_i = 1;
        redirect(3, 32'h0000_0100);
        go("f3", 1, 0, 32'h0000_0000);
        do_reset();
        idle_inputs();
        go("f4", 1, 0, 32'h0000);
        go("f5", 1, 1, 32'h1000);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            stall_i           = ($urandom_range(0, 3) == 0);
            thread_en_i       = 4'($urandom);
            redirect_valid_i  = ($urandom_range(0, 4) == 0);
            redirect_thread_i = 2'($urandom);
            redirect_pc_i     = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
